// File: rtl/button_stepper_pkg.sv
// Shared helpers for the button stepper: the LED bank size and its one-hot decode.
package button_stepper_pkg;

    localparam int LED_COUNT = 8;

    function automatic logic [LED_COUNT-1:0] led_onehot(input logic [2:0] pos);
        return 8'b1 << pos;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push button: two-flop synchronizer, stability counter, debounced level and
// a registered one-cycle pulse on each debounced rising level.
module button_debounce #(
    parameter int LOG2DEBOUNCE = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic lvl,
    output logic press
);

    logic [1:0]              sync;
    logic [LOG2DEBOUNCE-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync  <= '0;
            cnt   <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            // Any sample that agrees with the current level restarts the window.
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                lvl   <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_stepper.sv
// Steps a BITS-wide position up on SW1 and down on SW2 (wrapping) and shows it
// one-hot on LED0..LED7.
module button_stepper
    import button_stepper_pkg::*;
#(
    parameter int BITS         = 3,
    parameter int LOG2DEBOUNCE = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            SW1,
    input  logic            SW2,
    output logic            press1,
    output logic            press2,
    output logic [BITS-1:0] position,
    output logic            LED0,
    output logic            LED1,
    output logic            LED2,
    output logic            LED3,
    output logic            LED4,
    output logic            LED5,
    output logic            LED6,
    output logic            LED7
);

    logic                 lvl1_unused;
    logic                 lvl2_unused;
    logic [BITS-1:0]      pos_next;
    logic [LED_COUNT-1:0] leds;

    button_debounce #(.LOG2DEBOUNCE(LOG2DEBOUNCE)) u_db1 (
        .clk    (clk),
        .resetn (resetn),
        .raw    (SW1),
        .lvl    (lvl1_unused),
        .press  (press1)
    );

    button_debounce #(.LOG2DEBOUNCE(LOG2DEBOUNCE)) u_db2 (
        .clk    (clk),
        .resetn (resetn),
        .raw    (SW2),
        .lvl    (lvl2_unused),
        .press  (press2)
    );

    // Simultaneous presses cancel; wrap comes from natural BITS-wide overflow.
    always_comb begin
        pos_next = position;
        if (press1 && !press2) begin
            pos_next = position + BITS'(1);
        end else if (press2 && !press1) begin
            pos_next = position - BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            position <= '0;
            leds     <= 8'b0000_0001;
        end else begin
            position <= pos_next;
            leds     <= led_onehot(3'(pos_next));
        end
    end

    assign LED0 = leds[0];
    assign LED1 = leds[1];
    assign LED2 = leds[2];
    assign LED3 = leds[3];
    assign LED4 = leds[4];
    assign LED5 = leds[5];
    assign LED6 = leds[6];
    assign LED7 = leds[7];

endmodule
